delay_commutator: RTL

Radix-4 delay-commutator stage for the R4MDC FFT datapath: takes four parallel sample lanes, applies the input delay ladder, rotates the lanes through a 4-way commutator and applies the output delay ladder, so that each group of 4×D samples leaves transposed across lanes. It sits between radix-4 butterflies: its inputs come from the upstream butterfly, its outputs feed the next butterfly, and it advances only while the controller's commutator enable (Enable_comm1 / Enable_comm2) is high.

---
 rtl/r4mdc_pkg.sv | 14 +
 rtl/shift_delay.sv | 31 +++
 rtl/delay_commutator.sv | 97 +++++++++
 3 files changed

// File: rtl/r4mdc_pkg.sv
// Shared types and constants for the R4MDC FFT datapath.
// Lane count, phase type and counter-width helper.
package r4mdc_pkg;

  localparam int LANES      = 4;
  localparam int DATA_W_DEF = 32;

  typedef logic [1:0] phase_t;

  function automatic int cnt_w(input int d);
    return (d > 1) ? $clog2(d) : 1;
  endfunction

endpackage

// File: rtl/shift_delay.sv
// Enable-gated shift register of DEPTH stages.
// DEPTH of 0 degenerates to a plain wire.
module shift_delay #(
  parameter int W     = 32,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  if (DEPTH == 0) begin : g_wire
    assign q = d;
  end else begin : g_regs
    logic [W-1:0] sr [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
      end else if (en) begin
        sr[0] <= d;
        for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
      end
    end

    assign q = sr[DEPTH-1];
  end

endmodule

// File: rtl/delay_commutator.sv
// Radix-4 delay-commutator: input ladder, 4-way rotation,
// output ladder; each 4*D sample group leaves lane-transposed.
module delay_commutator
  import r4mdc_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int D      = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] in0,
  input  logic [DATA_W-1:0] in1,
  input  logic [DATA_W-1:0] in2,
  input  logic [DATA_W-1:0] in3,
  output logic [DATA_W-1:0] out0,
  output logic [DATA_W-1:0] out1,
  output logic [DATA_W-1:0] out2,
  output logic [DATA_W-1:0] out3,
  output logic              out_valid
);

  localparam int CW = cnt_w(D);
  localparam int FW = $clog2(3 * D + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(D - 1);
  localparam logic [FW-1:0] FILL_MAX = FW'(3 * D);

  logic [DATA_W-1:0] din  [LANES];
  logic [DATA_W-1:0] dly  [LANES];
  logic [DATA_W-1:0] mid  [LANES];
  logic [DATA_W-1:0] dout [LANES];

  logic [CW-1:0] cnt;
  logic [FW-1:0] fill;
  phase_t        p;

  assign din[0] = in0;
  assign din[1] = in1;
  assign din[2] = in2;
  assign din[3] = in3;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    if (i == 0) begin : g_in_wire
      assign dly[i] = din[i];
    end else begin : g_in_dly
      shift_delay #(.W(DATA_W), .DEPTH(i * D)) u_in (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .d   (din[i]),
        .q   (dly[i])
      );
    end

    if (i == LANES - 1) begin : g_out_wire
      assign dout[i] = mid[i];
    end else begin : g_out_dly
      shift_delay #(.W(DATA_W), .DEPTH((LANES - 1 - i) * D)) u_out (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .d   (mid[i]),
        .q   (dout[i])
      );
    end
  end

  // Lane j takes delayed lane (p - j) mod 4; 2-bit wrap does the mod.
  always_comb begin
    for (int j = 0; j < LANES; j++) begin
      mid[j] = dly[p - phase_t'(j)];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      p    <= '0;
      fill <= '0;
    end else if (en) begin
      if (cnt == CNT_LAST) begin
        cnt <= '0;
        p   <= p + 2'd1;
      end else begin
        cnt <= cnt + 1'b1;
      end
      if (fill != FILL_MAX) fill <= fill + 1'b1;
    end
  end

  assign out0      = dout[0];
  assign out1      = dout[1];
  assign out2      = dout[2];
  assign out3      = dout[3];
  assign out_valid = en && (fill == FILL_MAX);

endmodule
